// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: registers MEM-stage results and drives the register file write port.
// Slow loads park in WAIT_MEM, holding busy high until memReady, flush or a bounded timeout.
module mem_wb_writeback #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LOAD_TIMEOUT   = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      validIn,
    input  logic                      stallIn,
    input  logic                      flush,
    input  logic                      regWriteIn,
    input  logic                      memToRegIn,
    input  logic [REG_ADDR_WIDTH-1:0] writeRegisterIn,
    input  logic [DATA_WIDTH-1:0]     aluResultIn,
    input  logic [DATA_WIDTH-1:0]     memReadData,
    input  logic                      memReady,
    output logic                      regWrite,
    output logic [REG_ADDR_WIDTH-1:0] writeRegister,
    output logic [DATA_WIDTH-1:0]     writeData,
    output logic                      busy,
    output logic                      loadError
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t                    state, state_next;
    logic [7:0]                count, count_next;
    logic [REG_ADDR_WIDTH-1:0] pend_reg, pend_reg_next;
    logic [REG_ADDR_WIDTH-1:0] wreg_next;
    logic [DATA_WIDTH-1:0]     wdata_next;
    logic                      wr_next, err_next, accept;

    assign busy   = (state == WAIT_MEM);
    assign accept = (state == IDLE) && validIn && !stallIn && !flush;

    always_comb begin
        state_next    = state;
        count_next    = count;
        pend_reg_next = pend_reg;
        wr_next       = 1'b0;
        err_next      = 1'b0;
        wreg_next     = writeRegister;
        wdata_next    = writeData;
        if (state == IDLE) begin
            if (accept && memToRegIn && regWriteIn && !memReady) begin
                state_next    = WAIT_MEM;
                count_next    = 8'd0;
                pend_reg_next = writeRegisterIn;
            end else if (accept) begin
                wr_next    = regWriteIn && (writeRegisterIn != '0);
                wreg_next  = writeRegisterIn;
                wdata_next = memToRegIn ? memReadData : aluResultIn;
            end
        end else if (flush) begin
            state_next = IDLE;
        end else if (memReady) begin
            state_next = IDLE;
            wr_next    = (pend_reg != '0);
            wreg_next  = pend_reg;
            wdata_next = memReadData;
        end else if (count == 8'(LOAD_TIMEOUT - 1)) begin
            state_next = IDLE;
            err_next   = 1'b1;
        end else begin
            count_next = count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            pend_reg      <= '0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            loadError     <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            pend_reg      <= pend_reg_next;
            regWrite      <= wr_next;
            writeRegister <= wreg_next;
            writeData     <= wdata_next;
            loadError     <= err_next;
        end
    end
endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_wb_writeback;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset, validIn, stallIn, flush, regWriteIn, memToRegIn, memReady;
    logic [AW-1:0] writeRegisterIn;
    logic [DW-1:0] aluResultIn, memReadData;
    logic          regWrite, busy, loadError;
    logic [AW-1:0] writeRegister;
    logic [DW-1:0] writeData;

    int checks = 0;
    int failures = 0;

    // Model: a pending load is an outstanding transaction with an age in cycles.
    bit            m_pend;
    int            m_age;
    logic [AW-1:0] m_dest;
    logic          m_wr, m_err;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data;

    mem_wb_writeback #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .LOAD_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .validIn(validIn), .stallIn(stallIn), .flush(flush),
        .regWriteIn(regWriteIn), .memToRegIn(memToRegIn), .writeRegisterIn(writeRegisterIn),
        .aluResultIn(aluResultIn), .memReadData(memReadData), .memReady(memReady),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
        .busy(busy), .loadError(loadError)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        m_wr  = 1'b0;
        m_err = 1'b0;
        if (reset) begin
            m_pend = 0;
            m_age  = 0;
            m_reg  = '0;
            m_data = '0;
        end else if (m_pend) begin
            if (flush) m_pend = 0;
            else if (memReady) begin
                m_pend = 0;
                m_wr   = (m_dest != 0);
                m_reg  = m_dest;
                m_data = memReadData;
            end else if (m_age + 1 >= TO) begin
                m_pend = 0;
                m_err  = 1'b1;
            end else m_age++;
        end else if (validIn && !stallIn && !flush) begin
            if (memToRegIn && regWriteIn && !memReady) begin
                m_pend = 1;
                m_age  = 0;
                m_dest = writeRegisterIn;
            end else begin
                m_wr   = regWriteIn && (writeRegisterIn != 0);
                m_reg  = writeRegisterIn;
                m_data = memToRegIn ? memReadData : aluResultIn;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; validIn = 0; stallIn = 0; flush = 0; regWriteIn = 0; memToRegIn = 0;
        memReady = 0; writeRegisterIn = '0; aluResultIn = '0; memReadData = '0;
    endtask

    task automatic present(input logic rw, input logic m2r, input logic [AW-1:0] rd, input logic [DW-1:0] alu);
        validIn = 1; regWriteIn = rw; memToRegIn = m2r; writeRegisterIn = rd; aluResultIn = alu;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
        checks++;
        if ({regWrite, writeRegister, writeData, busy, loadError} !== '0) begin
            failures++;
            $display("FAIL reset: got wr=%0b reg=%0d data=%h busy=%0b err=%0b, want all 0",
                     regWrite, writeRegister, writeData, busy, loadError);
        end
    endtask

    task automatic test_alu_write();
        present(1, 0, 5'd8, 32'h0000_002A);
        cycle();
        validIn = 0;
        checks++;
        if ({regWrite, writeRegister, writeData, busy} !== {1'b1, 5'd8, 32'h2A, 1'b0}) begin
            failures++;
            $display("FAIL alu_write: got wr=%0b reg=%0d data=%h busy=%0b, want 1 8 0000002a 0",
                     regWrite, writeRegister, writeData, busy);
        end
        cycle();
        checks++;
        if ({regWrite, writeRegister, writeData} !== {1'b0, 5'd8, 32'h2A}) begin
            failures++;
            $display("FAIL alu_idle_hold: got wr=%0b reg=%0d data=%h, want 0 8 0000002a",
                     regWrite, writeRegister, writeData);
        end
    endtask

    task automatic test_reg0();
        present(1, 0, 5'd0, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            cycle();
            validIn = 0;
            checks++;
            if (regWrite !== 1'b0 || (i == 0 && {writeRegister, writeData} !== {5'd0, 32'hFFFF_FFFF})) begin
                failures++;
                $display("FAIL reg0 cycle %0d: got wr=%0b reg=%0d data=%h, want wr=0 reg=0 data=ffffffff",
                         i, regWrite, writeRegister, writeData);
            end
        end
    endtask

    task automatic test_slow_load();
        int busy_cnt = 0;
        present(1, 1, 5'd9, 32'h0);
        cycle();
        validIn = 0;
        for (int i = 0; i < 3; i++) begin
            busy_cnt += int'(busy);
            if (i == 2) begin memReady = 1; memReadData = 32'h1234_5678; end
            cycle();
        end
        memReady = 0;
        checks++;
        if (busy_cnt != 3 || {regWrite, writeRegister, writeData, busy} !== {1'b1, 5'd9, 32'h1234_5678, 1'b0}) begin
            failures++;
            $display("FAIL slow_load: got busy_cycles=%0d wr=%0b reg=%0d data=%h busy=%0b, want 3 1 9 12345678 0",
                     busy_cnt, regWrite, writeRegister, writeData, busy);
        end
    endtask

    task automatic test_timeout();
        int busy_cnt = 0;
        int wr_seen = 0;
        present(1, 1, 5'd3, 32'h0);
        cycle();
        validIn = 0;
        while (busy && busy_cnt < 20) begin
            busy_cnt++;
            wr_seen += int'(regWrite);
            cycle();
        end
        checks++;
        if (busy_cnt != TO || loadError !== 1'b1 || regWrite !== 1'b0 || wr_seen != 0) begin
            failures++;
            $display("FAIL timeout: got busy_cycles=%0d err=%0b wr=%0b writes=%0d, want %0d 1 0 0",
                     busy_cnt, loadError, regWrite, wr_seen, TO);
        end
        cycle();
        checks++;
        if (loadError !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: got err=%0b one cycle later, want 0", loadError);
        end
    endtask

    task automatic test_flush_stall();
        present(1, 1, 5'd4, 32'h0);
        cycle();
        validIn = 0;
        flush = 1;
        cycle();
        flush = 0;
        checks++;
        if (busy !== 1'b0 || regWrite !== 1'b0 || loadError !== 1'b0) begin
            failures++;
            $display("FAIL flush_wait: got busy=%0b wr=%0b err=%0b, want 0 0 0", busy, regWrite, loadError);
        end
        present(1, 0, 5'd5, 32'hDEAD_BEEF);
        stallIn = 1;
        cycle();
        stallIn = 0;
        flush = 1;
        cycle();
        flush = 0;
        validIn = 0;
        checks++;
        if (regWrite !== 1'b0 || writeData === 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL stall_flush_idle: got wr=%0b data=%h, want wr=0 and no deadbeef", regWrite, writeData);
        end
    endtask

    task automatic test_reset_mid_load();
        present(1, 1, 5'd7, 32'h0);
        cycle();
        validIn = 0;
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        checks++;
        if ({regWrite, writeRegister, writeData, busy, loadError} !== '0) begin
            failures++;
            $display("FAIL reset_mid_load: got wr=%0b reg=%0d data=%h busy=%0b err=%0b, want all 0",
                     regWrite, writeRegister, writeData, busy, loadError);
        end
        memReady = 1;
        memReadData = 32'hCAFE_0001;
        cycle();
        memReady = 0;
        checks++;
        if (regWrite !== 1'b0) begin
            failures++;
            $display("FAIL reset_late_ready: got wr=%0b, want 0", regWrite);
        end
    endtask

    task automatic test_back_to_back();
        present(1, 1, 5'd10, 32'h0);
        cycle();
        present(1, 0, 5'd11, 32'h0000_0BBB);
        memReady = 1;
        memReadData = 32'h0000_0AAA;
        cycle();
        memReady = 0;
        checks++;
        if ({regWrite, writeRegister, writeData} !== {1'b1, 5'd10, 32'hAAA}) begin
            failures++;
            $display("FAIL b2b_load: got wr=%0b reg=%0d data=%h, want 1 10 00000aaa", regWrite, writeRegister, writeData);
        end
        cycle();
        validIn = 0;
        checks++;
        if ({regWrite, writeRegister, writeData} !== {1'b1, 5'd11, 32'hBBB}) begin
            failures++;
            $display("FAIL b2b_alu: got wr=%0b reg=%0d data=%h, want 1 11 00000bbb", regWrite, writeRegister, writeData);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 199) == 0);
            validIn         = ($urandom_range(0, 3) != 0);
            stallIn         = ($urandom_range(0, 5) == 0);
            flush           = ($urandom_range(0, 15) == 0);
            regWriteIn      = ($urandom_range(0, 5) != 0);
            memToRegIn      = $urandom_range(0, 1) == 1;
            memReady        = ($urandom_range(0, 3) == 0);
            writeRegisterIn = AW'($urandom_range(0, 7) == 0 ? 0 : $urandom);
            aluResultIn     = $urandom;
            memReadData     = $urandom;
            cycle();
            checks++;
            if ({regWrite, writeRegister, writeData, busy, loadError} !== {m_wr, m_reg, m_data, 1'(m_pend), m_err}) begin
                failures++;
                $display("FAIL random cycle %0d: got wr=%0b reg=%0d data=%h busy=%0b err=%0b, want %0b %0d %h %0b %0b",
                         i, regWrite, writeRegister, writeData, busy, loadError,
                         m_wr, m_reg, m_data, m_pend, m_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_pend = 0; m_age = 0; m_dest = '0; m_wr = 0; m_err = 0; m_reg = '0; m_data = '0;
        test_reset();
        test_alu_write();
        test_reg0();
        test_slow_load();
        test_timeout();
        test_flush_stall();
        test_reset_mid_load();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- Writeback-side producer for the register file write port: registers MEM-stage results and drives regWrite/writeRegister/writeData into the decode-stage register file.
- Selects the ALU result or the load data (memToReg). Suppresses writes to register 0.
- Waits for slow data-memory loads with a bounded timeout, back-pressuring the pipeline through busy.
- Sits between the memory-access stage and the instruction-decode register database.

Parameters:
- DATA_WIDTH, 32, width of ALU result, load data and write data.
- REG_ADDR_WIDTH, 5, register index width (32 registers).
- LOAD_TIMEOUT, 15, maximum WAIT_MEM cycles before a pending load is dropped; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- validIn  input  1  MEM stage presents an instruction this cycle.
- stallIn  input  1  upstream hold; no acceptance while high.
- flush  input  1  discard the instruction being presented and any pending load.
- regWriteIn  input  1  instruction writes a register.
- memToRegIn  input  1  1 = write load data, 0 = write ALU result.
- writeRegisterIn  input  REG_ADDR_WIDTH  destination register.
- aluResultIn  input  DATA_WIDTH  ALU result.
- memReadData  input  DATA_WIDTH  data-memory read data; valid when memReady = 1.
- memReady  input  1  data memory read data valid.
- regWrite  output  1  write enable to the register file (one-cycle pulse).
- writeRegister  output  REG_ADDR_WIDTH  write address to the register file.
- writeData  output  DATA_WIDTH  write data to the register file.
- busy  output  1  high while in WAIT_MEM; upstream must hold its instruction.
- loadError  output  1  one-cycle pulse when a pending load times out.

Behaviour:
- Reset: the cycle after reset is sampled high:
  - regWrite, writeRegister, writeData, busy and loadError are all 0.
  - state = IDLE, wait counter = 0.
  - Reset while in WAIT_MEM aborts the pending load; no write is issued.
- Accept condition: state = IDLE && validIn && !stallIn && !flush. No other cycle accepts.
- States: IDLE and WAIT_MEM. busy = (state == WAIT_MEM), decoded from the state register.
- IDLE, accepted instruction with (memToRegIn == 0 || memReady == 1):
  - The next cycle drives writeRegister = writeRegisterIn.
  - writeData = aluResultIn if memToRegIn = 0, else memReadData.
  - regWrite = regWriteIn && (writeRegisterIn != 0).
  - Latency is exactly 1 cycle.
- IDLE, accepted instruction with memToRegIn = 1 && regWriteIn = 1 && memReady = 0:
  - Latch the destination register, counter = 0, go to WAIT_MEM.
  - regWrite = 0 the next cycle.
- WAIT_MEM exits, in priority order:
  1. flush: go to IDLE, no write, no error.
  2. memReady: the next cycle drives regWrite (subject to the register-0 rule), writeData = memReadData captured on that edge, the latched destination, and goes to IDLE.
  3. Counter == LOAD_TIMEOUT-1: go to IDLE; the next cycle loadError = 1 for one cycle and regWrite = 0.
  4. Otherwise: counter increments by 1.
- Inputs other than memReady and flush are ignored in WAIT_MEM.
- Back-to-back operation: an instruction accepted in the cycle right after WAIT_MEM exits writes one cycle after the load's write. The two writes never share a cycle.
- Register-0 rule: writes to register 0 never assert regWrite. writeRegister and writeData still update.
- Idle cycles: regWrite = 0 in every cycle not following an accepted/completed instruction. writeRegister and writeData hold their last values.
- Non-write instructions: regWriteIn = 0 with memToRegIn = 1 never enters WAIT_MEM; it completes in 1 cycle with regWrite = 0.

Test Plan:
- ALU write: reset, then accept regWriteIn=1, memToRegIn=0, writeRegisterIn=8, aluResultIn=0x0000_002A -> next cycle regWrite=1, writeRegister=8, writeData=0x2A. The cycle after, regWrite=0.
- Register 0: accept a write to register 0 with aluResultIn=0xFFFF_FFFF -> regWrite stays 0 in every cycle.
- Slow load: accept a load to register 9 with memReady=0; raise memReady with memReadData=0x1234_5678 three cycles later -> busy=1 for 3 cycles; the cycle after memReady, regWrite=1, writeRegister=9, writeData=0x12345678, busy=0.
- Timeout: LOAD_TIMEOUT=4, load accepted, memReady never asserted -> busy=1 for 4 cycles, then a loadError pulse of 1 cycle, regWrite never 1.
- Flush and stall: flush during WAIT_MEM -> next cycle busy=0, no write. stallIn=1 with validIn=1 -> no regWrite.
- Reset mid-load: assert reset in the second WAIT_MEM cycle -> all outputs 0 next cycle; a later memReady causes no write.
